// File: rtl/imem_port_arbiter.sv
// Single-port instruction SRAM arbiter between fetch (read-only) and a loader/debug port.
// Loader has priority, but only until it has won MAX_BURST grants in a row while fetch waits.
module imem_port_arbiter #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 1024,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_req,
    input  logic [WIDTH-1:0] fetch_addr,
    output logic             fetch_gnt,
    output logic             fetch_rvalid,
    output logic [WIDTH-1:0] fetch_rdata,
    input  logic             ldr_valid,
    input  logic             ldr_write,
    input  logic [WIDTH-1:0] ldr_addr,
    input  logic [WIDTH-1:0] ldr_wdata,
    output logic             ldr_ready,
    output logic             ldr_rvalid,
    output logic [WIDTH-1:0] ldr_rdata,
    output logic             mem_enable,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    if (MAX_BURST < 1 || MAX_BURST > 15 || DEPTH < 1) begin : g_bad_cfg
        $error("imem_port_arbiter: MAX_BURST must be 1..15 and DEPTH positive");
    end

    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LDR} owner_t;

    localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

    owner_t     owner;
    logic [3:0] cnt;
    logic       ldr_win;
    logic       fetch_win;

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        ldr_win   = rst_n && ldr_valid && !(fetch_req && cnt == BURST_CAP);
        fetch_win = rst_n && fetch_req && !ldr_win;
    end

    assign ldr_ready   = ldr_win;
    assign fetch_gnt   = fetch_win;
    assign mem_enable  = ldr_win || fetch_win;
    assign mem_write   = ldr_win && ldr_write;
    assign mem_address = ldr_win ? ldr_addr : fetch_addr;
    assign mem_wdata   = ldr_win ? ldr_wdata : '0;

    // A read issued just before reset must not surface in the reset cycle.
    assign fetch_rvalid = rst_n && (owner == OWN_FETCH);
    assign ldr_rvalid   = rst_n && (owner == OWN_LDR);
    assign fetch_rdata  = mem_rdata;
    assign ldr_rdata    = mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= 4'd0;
            owner <= OWN_NONE;
        end else begin
            if (ldr_win && fetch_req)
                cnt <= cnt + 4'd1;
            else
                cnt <= 4'd0;

            if (fetch_win)
                owner <= OWN_FETCH;
            else if (ldr_win && !ldr_write)
                owner <= OWN_LDR;
            else
                owner <= OWN_NONE;
        end
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
Shares the single-port instruction SRAM between the fetch stage and a program loader/debug port. The fetch stage reads only. The loader reads or writes through a valid/ready handshake. The block picks one requester per cycle and drives the SRAM command. It tracks which requester owns the 1-cycle-latency read return and steers the returned data to that requester. A burst limit stops the loader from starving fetch indefinitely.

Parameters:
WIDTH, 32, data and address width in bits
DEPTH, 1024, SRAM depth in words; passed through for address-range documentation only
MAX_BURST, 4, maximum consecutive loader grants while fetch is requesting; legal range is 1..15

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset
fetch_req  in  1  fetch wants a read this cycle
fetch_addr  in  WIDTH  fetch byte address
fetch_gnt  out  1  fetch read issued to the SRAM this cycle; when low, fetch must stall and hold fetch_addr
fetch_rvalid  out  1  fetch_rdata is valid this cycle
fetch_rdata  out  WIDTH  instruction word returned to fetch
ldr_valid  in  1  loader request valid
ldr_write  in  1  1 = write, 0 = read
ldr_addr  in  WIDTH  loader byte address
ldr_wdata  in  WIDTH  loader write data
ldr_ready  out  1  loader request accepted this cycle
ldr_rvalid  out  1  ldr_rdata is valid this cycle
ldr_rdata  out  WIDTH  data returned for a loader read
mem_enable  out  1  SRAM access strobe
mem_write  out  1  SRAM write strobe; only asserted together with mem_enable
mem_address  out  WIDTH  SRAM byte address
mem_wdata  out  WIDTH  SRAM write data
mem_rdata  in  WIDTH  SRAM read data; valid one cycle after a read is issued

Behaviour:
- State registers:
  - burst counter cnt, width 4
  - read-owner tag owner, one of NONE, FETCH, LDR
- Arbitration is combinational within the cycle:
  - Loader wins if ldr_valid && !(fetch_req && cnt == MAX_BURST).
  - Otherwise fetch wins if fetch_req.
  - Otherwise the cycle is idle.
- Winner = loader:
  - ldr_ready = 1, fetch_gnt = 0.
  - mem_enable = 1, mem_write = ldr_write, mem_address = ldr_addr, mem_wdata = ldr_wdata.
- Winner = fetch:
  - fetch_gnt = 1, ldr_ready = 0.
  - mem_enable = 1, mem_write = 0, mem_address = fetch_addr.
- Idle cycle:
  - mem_enable = 0, mem_write = 0, mem_address = fetch_addr, mem_wdata = 0.
- Counter update on each clock edge:
  - Loader granted and fetch_req = 1: cnt <= cnt + 1.
  - Fetch granted, or fetch_req = 0: cnt <= 0.
  - cnt never exceeds MAX_BURST.
- Read-return tracking:
  - owner <= FETCH after a fetch grant.
  - owner <= LDR after a loader read grant.
  - owner <= NONE after a loader write or an idle cycle.
- Return outputs:
  - fetch_rvalid = (owner == FETCH); ldr_rvalid = (owner == LDR).
  - fetch_rdata = mem_rdata and ldr_rdata = mem_rdata, unconditionally.
- Latency: the request is granted in cycle N and its data returns in cycle N+1. Back-to-back throughput is 1 access per cycle.
- While rst_n = 0:
  - All grant, strobe and rvalid outputs are 0.
  - cnt = 0, owner = NONE.
  - Requests presented during reset are not accepted.
- Reset mid-operation: an outstanding read is discarded. The first cycle after rst_n rises has fetch_rvalid = ldr_rvalid = 0.
- Both requesters request and cnt < MAX_BURST: loader wins.
- Both requesters request and cnt == MAX_BURST: fetch wins for exactly one cycle, then cnt = 0.
- The loader must hold ldr_* stable while ldr_valid && !ldr_ready. The arbiter does not check this.
- Addresses pass through unmodified. Alignment and range are the requester's responsibility.

Test Plan:
- Reset hold: rst_n = 0 for 3 cycles with fetch_req = ldr_valid = 1 -> all grants, strobes and rvalids are 0; after release, cycle 1 has fetch_rvalid = 0.
- Fetch only: fetch_req = 1, addresses 0x0, 0x4, 0x8 on consecutive cycles -> fetch_gnt = 1 every cycle; fetch_rvalid = 1 one cycle later with the matching SRAM words; ldr_rvalid = 0.
- Loader write then read: write 0xDEADBEEF to 0x10, then read 0x10 with fetch idle -> ldr_ready = 1 both cycles; mem_write = 1 only on the first cycle; ldr_rvalid = 1 with 0xDEADBEEF the cycle after the read.
- Starvation limit: MAX_BURST = 4, fetch_req and ldr_valid held high for 12 cycles -> grant pattern L,L,L,L,F,L,L,L,L,F,L,L; fetch_rvalid is 1 in the cycle after each F.
- Mixed read returns: loader read of 0x20 at cycle N, fetch read of 0x24 at N+1 -> ldr_rvalid at N+1 only, fetch_rvalid at N+2 only, each with the correct data.
- Reset mid-read: fetch granted at cycle N, rst_n = 0 at N+1 -> fetch_rvalid = 0 at N+1 and N+2; cnt = 0 and owner = NONE after release.
